// File: rtl/fifo_burst_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_rd_ctrl
// Purpose  : Burst read scheduler for a line FIFO with a credit-managed skid
//            buffer that absorbs the FIFO read latency under backpressure.
// Revision : 1.0
// ============================================================================
module fifo_burst_rd_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_W      = 12,
    parameter int BURST_LEN  = 64,
    parameter int RD_LATENCY = 1,
    parameter int SKID_DEPTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  rd_clk,
    input  logic                  sys_rst_n,
    input  logic                  enable,
    input  logic                  fifo_rst_busy,
    input  logic                  fifo_empty,
    input  logic [CNT_W-1:0]      fifo_rd_count,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_rd_valid,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic [15:0]           burst_cnt,
    output logic                  abort_err,
    output logic                  spurious_err
);

    localparam int c_SK_AW  = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int c_OCC_W  = $clog2(SKID_DEPTH + 1);
    localparam int c_TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0]   c_BURST   = CNT_W'(BURST_LEN);
    localparam logic [c_TMR_W-1:0] c_TMR_MAX = c_TMR_W'(TIMEOUT - 1);
    localparam logic [c_OCC_W:0]   c_SKID    = (c_OCC_W + 1)'(SKID_DEPTH);
    localparam logic [c_SK_AW-1:0] c_PTR_TOP = c_SK_AW'(SKID_DEPTH - 1);

    generate
        if (SKID_DEPTH < RD_LATENCY + 2) begin : g_bad_cfg
            $error("SKID_DEPTH must be at least RD_LATENCY+2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_len;
    logic [CNT_W-1:0]      r_issued;
    logic [CNT_W-1:0]      r_rcvd;
    logic [c_TMR_W-1:0]    r_idle_tmr;
    logic [c_OCC_W-1:0]    r_outst;
    logic [c_OCC_W-1:0]    r_occ;
    logic [c_SK_AW-1:0]    r_wr_ptr;
    logic [c_SK_AW-1:0]    r_rd_ptr;
    logic [DATA_WIDTH:0]   r_mem [SKID_DEPTH];
    logic                  r_m_valid;
    logic                  r_m_last;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic [15:0]           r_burst_cnt;
    logic                  r_abort_err;
    logic                  r_spur_err;

    logic                  w_credit_ok;
    logic                  w_rd_en;
    logic                  w_abort;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_spur;
    logic                  w_push_last;
    logic                  w_in_range;
    logic                  w_full_ok;
    logic [c_OCC_W-1:0]    w_occ_after_pop;
    logic [c_OCC_W-1:0]    w_occ_nxt;
    logic [c_SK_AW-1:0]    w_rd_ptr_nxt;
    logic [DATA_WIDTH:0]   w_head_nxt;

    function automatic logic [c_SK_AW-1:0] f_inc(input logic [c_SK_AW-1:0] p);
        return (p == c_PTR_TOP) ? '0 : p + 1'b1;
    endfunction

    // Words in flight plus words parked in the skid never exceed SKID_DEPTH.
    assign w_credit_ok = ({1'b0, r_outst} + {1'b0, r_occ}) < c_SKID;
    assign w_rd_en     = (r_state == S_ISSUE) & ~fifo_rst_busy & ~fifo_empty &
                         (r_issued < r_len) & w_credit_ok;
    assign w_abort     = fifo_rst_busy & (r_state != S_IDLE);
    assign w_push      = fifo_rd_valid & (r_outst != '0);
    assign w_spur      = fifo_rd_valid & (r_outst == '0);
    assign w_pop       = r_m_valid & m_ready;
    assign w_push_last = (r_rcvd == r_len - 1'b1);
    assign w_in_range  = (fifo_rd_count != '0) & (fifo_rd_count < c_BURST);
    assign w_full_ok   = (fifo_rd_count >= c_BURST);

    assign w_occ_after_pop = r_occ - c_OCC_W'(w_pop);
    assign w_occ_nxt       = w_occ_after_pop + c_OCC_W'(w_push);
    assign w_rd_ptr_nxt    = w_pop ? f_inc(r_rd_ptr) : r_rd_ptr;
    // An empty skid forwards the arriving word straight into the output register.
    assign w_head_nxt      = (w_occ_after_pop == '0) ? {w_push_last, fifo_rdata}
                                                     : r_mem[w_rd_ptr_nxt];

    always_ff @(posedge rd_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_push_last, fifo_rdata};
        end
    end

    always_ff @(posedge rd_clk) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_issued    <= '0;
            r_rcvd      <= '0;
            r_idle_tmr  <= '0;
            r_outst     <= '0;
            r_occ       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_m_data    <= '0;
            r_burst_cnt <= '0;
            r_abort_err <= 1'b0;
            r_spur_err  <= 1'b0;
        end else begin
            if (w_spur) begin
                r_spur_err <= 1'b1;
            end
            if (w_abort) begin
                r_state     <= S_IDLE;
                r_outst     <= '0;
                r_occ       <= '0;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_m_valid   <= 1'b0;
                r_m_last    <= 1'b0;
                r_idle_tmr  <= '0;
                r_abort_err <= 1'b1;
            end else begin
                case ({w_rd_en, w_push})
                    2'b10:   r_outst <= r_outst + 1'b1;
                    2'b01:   r_outst <= r_outst - 1'b1;
                    default: r_outst <= r_outst;
                endcase
                r_occ     <= w_occ_nxt;
                r_rd_ptr  <= w_rd_ptr_nxt;
                r_m_valid <= (w_occ_nxt != '0);
                if (w_occ_nxt != '0) begin
                    {r_m_last, r_m_data} <= w_head_nxt;
                end
                if (w_push) begin
                    r_wr_ptr <= f_inc(r_wr_ptr);
                    r_rcvd   <= r_rcvd + 1'b1;
                end
                if (w_rd_en) begin
                    r_issued <= r_issued + 1'b1;
                end

                case (r_state)
                    S_IDLE: begin
                        if (enable && !fifo_rst_busy && w_full_ok) begin
                            r_state    <= S_ISSUE;
                            r_len      <= c_BURST;
                            r_issued   <= '0;
                            r_rcvd     <= '0;
                            r_idle_tmr <= '0;
                        end else if (enable && !fifo_rst_busy && w_in_range &&
                                     (r_idle_tmr == c_TMR_MAX)) begin
                            r_state    <= S_ISSUE;
                            r_len      <= fifo_rd_count;
                            r_issued   <= '0;
                            r_rcvd     <= '0;
                            r_idle_tmr <= '0;
                        end else if (w_in_range) begin
                            // Saturate so a disabled block flushes as soon as it is re-enabled.
                            r_idle_tmr <= (r_idle_tmr == c_TMR_MAX) ? r_idle_tmr
                                                                     : r_idle_tmr + 1'b1;
                        end else begin
                            r_idle_tmr <= '0;
                        end
                    end
                    S_ISSUE: begin
                        if (w_rd_en && (r_issued == r_len - 1'b1)) begin
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if ((r_outst == '0) && (r_occ == '0)) begin
                            r_burst_cnt <= r_burst_cnt + 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign fifo_rd_en   = w_rd_en;
    assign m_valid      = r_m_valid;
    assign m_data       = r_m_data;
    assign m_last       = r_m_last;
    assign busy         = (r_state != S_IDLE);
    assign burst_cnt    = r_burst_cnt;
    assign abort_err    = r_abort_err;
    assign spurious_err = r_spur_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_burst_rd_ctrl
// Purpose  : Randomized scoreboard bench with a queue-based FIFO model.
// Revision : 1.0
// ============================================================================
module tb_fifo_burst_rd_ctrl;

    localparam int DW  = 16;
    localparam int CW  = 12;
    localparam int BL  = 16;
    localparam int LAT = 2;
    localparam int SK  = 4;
    localparam int TO  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          fifo_rst_busy;
    logic          fifo_empty;
    logic [CW-1:0] fifo_rd_count;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_rd_valid;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic [15:0]   burst_cnt;
    logic          abort_err;
    logic          spurious_err;

    always #5 clk = ~clk;

    fifo_burst_rd_ctrl #(
        .DATA_WIDTH(DW), .CNT_W(CW), .BURST_LEN(BL),
        .RD_LATENCY(LAT), .SKID_DEPTH(SK), .TIMEOUT(TO)
    ) dut (
        .rd_clk        (clk),
        .sys_rst_n     (rst_n),
        .enable        (enable),
        .fifo_rst_busy (fifo_rst_busy),
        .fifo_empty    (fifo_empty),
        .fifo_rd_count (fifo_rd_count),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rdata    (fifo_rdata),
        .fifo_rd_valid (fifo_rd_valid),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .busy          (busy),
        .burst_cnt     (burst_cnt),
        .abort_err     (abort_err),
        .spurious_err  (spurious_err)
    );

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] fq[$];
    logic          pv[LAT];
    logic [DW-1:0] pd[LAT];
    exp_t          mon_e;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_rden, n_hs;
    int   ph_rden, ph_first, ph_last, ph_start;
    int   ready_mode;
    int   exp_bursts;
    int   k;
    int   bc_before;
    bit   inj, do_abort;
    logic prev_stall;
    logic [DW-1:0] prev_data;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic set_pins();
        fifo_rd_count = CW'(fq.size());
        fifo_empty    = (fq.size() == 0);
    endtask

    // Monitor: pops the expected word whenever the consumer takes one.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && m_valid)
                check("hold_data", 32'(m_data), 32'(prev_data));
            if (m_valid && m_ready) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h expected none", m_data);
                end else begin
                    mon_e = sbq.pop_front();
                    check("out_word", 32'({m_last, m_data}), 32'({mon_e.last, mon_e.data}));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // One clock: sample at negedge, then model the FIFO response after the edge.
    task automatic step();
        logic          s_rden, s_hs, nv;
        logic [DW-1:0] nd;
        @(negedge clk);
        s_rden = fifo_rd_en;
        s_hs   = m_valid & m_ready;
        cyc++;
        if (rst_n) begin
            if (s_rden) n_rden++;
            if (s_hs)   n_hs++;
            check("inflight_bound", 32'(n_rden - n_hs > SK), 32'd0);
            if (s_rden) begin
                if (ph_rden == 0) ph_first = cyc;
                ph_last = cyc;
                ph_rden++;
            end
        end
        @(posedge clk);
        #1;
        nv = 1'b0;
        nd = '0;
        if (s_rden && rst_n) begin
            check("rd_nonempty", 32'(fq.size() != 0), 32'd1);
            if (fq.size() != 0) begin
                nd = fq.pop_front();
                nv = 1'b1;
            end
        end
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = nv;
        pd[0] = nd;
        fifo_rst_busy = 1'b0;
        if (do_abort) begin
            do_abort      = 1'b0;
            fifo_rst_busy = 1'b1;
            fq.delete();
            for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
        end
        fifo_rd_valid = pv[LAT-1] | inj;
        fifo_rdata    = pv[LAT-1] ? pd[LAT-1] : (inj ? 16'hDEAD : '0);
        inj = 1'b0;
        set_pins();
        case (ready_mode)
            1:       m_ready = 1'b1;
            2:       m_ready = 1'b0;
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    // Model: words leave in order, cut into BL-word bursts, remainder as one flush burst.
    task automatic push_words(input int n, input bit seq);
        exp_t          e;
        logic [DW-1:0] d;
        int            nfull;
        nfull = n / BL;
        for (int i = 0; i < n; i++) begin
            d = seq ? DW'(i) : DW'($urandom);
            fq.push_back(d);
            e.data = d;
            e.last = (i < nfull * BL) ? ((i % BL) == BL - 1) : (i == n - 1);
            sbq.push_back(e);
        end
        ph_rden  = 0;
        ph_start = cyc;
        set_pins();
    endtask

    task automatic run_phase(input int n, input int mode, input bit hold, input bit seq);
        int j;
        push_words(n, seq);
        exp_bursts += n / BL + ((n % BL) != 0 ? 1 : 0);
        ready_mode = mode;
        j = 0;
        while (j < 4000 && !(sbq.size() == 0 && fq.size() == 0 && !busy && !m_valid)) begin
            if (hold && j == 6)  ready_mode = 2;
            if (hold && j == 26) ready_mode = mode;
            step();
            j++;
        end
        check("phase_done", 32'(j < 4000), 32'd1);
        check("burst_cnt", 32'(burst_cnt), 32'(exp_bursts));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; fifo_rst_busy = 1'b0; fifo_empty = 1'b1;
        fifo_rd_count = '0; fifo_rdata = '0; fifo_rd_valid = 1'b0; m_ready = 1'b0;
        ready_mode = 1; exp_bursts = 0; n_rden = 0; n_hs = 0; ph_rden = 0;
        ph_first = 0; ph_last = 0; ph_start = 0; inj = 1'b0; do_abort = 1'b0;
        prev_stall = 1'b0; prev_data = '0;
        for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; end

        repeat (3) step();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_burst_cnt", 32'(burst_cnt), 32'd0);
        check("rst_errs", 32'({abort_err, spurious_err}), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);

        rst_n = 1'b1; enable = 1'b1;
        step();

        // Full burst at full throughput.
        run_phase(BL, 1, 1'b0, 1'b1);
        check("burst_rden_cnt", 32'(ph_rden), 32'(BL));
        check("burst_contiguous", 32'(ph_last - ph_first + 1), 32'(BL));

        // Partial count flushes after TIMEOUT idle cycles.
        run_phase(5, 1, 1'b0, 1'b0);
        check("flush_rden_cnt", 32'(ph_rden), 32'd5);
        check("flush_start", 32'(ph_first - ph_start), 32'(TO + 1));

        for (int r = 0; r < 5; r++)
            run_phase($urandom_range(1, 50), 0, 1'b0, 1'b0);

        // Consumer stalls 20 cycles mid-burst.
        run_phase(64, 0, 1'b1, 1'b1);

        // FIFO reset during a burst.
        push_words(2 * BL, 1'b0);
        ready_mode = 0;
        k = 0;
        while (k < 500 && ph_rden < 10) begin step(); k++; end
        check("abort_reach", 32'(k < 500), 32'd1);
        bc_before = int'(burst_cnt);
        do_abort = 1'b1;
        step();
        step();
        check("abort_err", 32'(abort_err), 32'd1);
        check("abort_m_valid", 32'(m_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_burst_cnt", 32'(burst_cnt), 32'(bc_before));
        sbq.delete();
        n_rden = 0; n_hs = 0;
        repeat (3) step();
        check("abort_sticky", 32'({abort_err, busy, m_valid}), 32'b100);

        // Read-valid with nothing outstanding.
        ready_mode = 1;
        check("spur_pre", 32'(spurious_err), 32'd0);
        inj = 1'b1;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check("spur_no_valid", 32'(m_valid), 32'd0);
        end
        check("spur_err", 32'(spurious_err), 32'd1);
        repeat (5) step();
        check("spur_sticky", 32'(spurious_err), 32'd1);

        // Reset in the middle of a burst.
        push_words(2 * BL, 1'b0);
        ready_mode = 0;
        k = 0;
        while (k < 500 && ph_rden < 5) begin step(); k++; end
        check("rst_reach", 32'(k < 500), 32'd1);
        rst_n = 1'b0;
        step();
        check("mrst_m_valid", 32'(m_valid), 32'd0);
        check("mrst_m_data", 32'({m_last, m_data}), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_burst_cnt", 32'(burst_cnt), 32'd0);
        check("mrst_errs", 32'({abort_err, spurious_err}), 32'd0);
        check("mrst_rd_en", 32'(fifo_rd_en), 32'd0);
        repeat (LAT + 2) step();
        fq.delete();
        sbq.delete();
        for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
        fifo_rd_valid = 1'b0;
        set_pins();
        n_rden = 0; n_hs = 0; exp_bursts = 0;
        rst_n = 1'b1;
        step();
        run_phase(BL + 3, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
